// File: rtl/ip_psram_bridge_if.sv
// Bus bundle between the cartridge RAM front-end, the PSRAM bridge and the
// 16-bit PSRAM controller core.
//   front-end side : rd, wr, address[21:0], wdata[7:0] -> busy, rdata[7:0], rdata_en
//   core side      : mem_cmd_en, mem_cmd, mem_addr[20:0], mem_wdata[15:0], mem_wmask[1:0]
//                    <- mem_cmd_ready, mem_rdata[15:0], mem_rdata_valid, mem_calib_done
//   status         : err_timeout
// slave  = the bridge; master = everything around it (front-end + core, or a bench).
interface ip_psram_bridge_if;
  logic        rd;
  logic        wr;
  logic [21:0] address;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        mem_cmd_en;
  logic        mem_cmd;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_cmd_ready;
  logic [15:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_calib_done;
  logic        err_timeout;

  modport slave (
    input  rd, wr, address, wdata,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid, mem_calib_done,
    output busy, rdata, rdata_en,
    output mem_cmd_en, mem_cmd, mem_addr, mem_wdata, mem_wmask,
    output err_timeout
  );

  modport master (
    output rd, wr, address, wdata,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid, mem_calib_done,
    input  busy, rdata, rdata_en,
    input  mem_cmd_en, mem_cmd, mem_addr, mem_wdata, mem_wmask,
    input  err_timeout
  );
endinterface

// File: rtl/ip_psram_bridge.sv
// Byte-wide rd/wr front-end to 16-bit PSRAM core bridge.
// Each accepted request becomes one single-word command; address[0] picks the
// byte lane. Reads are bounded by TIMEOUT_CYCLES so the bus never hangs.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : ip_psram_bridge_if.slave (front-end request/response + core command/data)
// Parameters:
//   TIMEOUT_CYCLES : cycles spent in RD_WAIT before a forced 8'hFF response (1..255)
//   WRITE_RECOVERY : idle cycles after a write is accepted by the core (1..15)
module ip_psram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned WRITE_RECOVERY = 4
) (
  input logic               clk,
  input logic               reset,
  ip_psram_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD_WAIT,
    WR_RECOVER
  } state_t;

  // Terminal counter values: the counter is 0 in the first cycle of a wait
  // state, so leaving when it holds N-1 gives exactly N cycles in that state.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] WR_LAST = 8'(WRITE_RECOVERY - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       lane_hi;

  assign bus.busy = !bus.mem_calib_done || (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      lane_hi         <= 1'b0;
      bus.mem_cmd_en  <= 1'b0;
      bus.mem_cmd     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wmask   <= '1;
      bus.rdata       <= '0;
      bus.rdata_en    <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      // rdata is only non-zero in the single strobe cycle.
      bus.rdata_en <= 1'b0;
      bus.rdata    <= '0;
      case (state)
        IDLE: begin
          if (bus.mem_calib_done && (bus.rd || bus.wr)) begin
            state          <= CMD;
            bus.mem_cmd_en <= 1'b1;
            // wr wins over a simultaneous rd; the rd is dropped.
            bus.mem_cmd    <= bus.wr;
            bus.mem_addr   <= bus.address[21:1];
            bus.mem_wdata  <= {2{bus.wdata}};
            if (bus.wr)
              bus.mem_wmask <= bus.address[0] ? 2'b01 : 2'b10;
            else
              bus.mem_wmask <= 2'b11;
            lane_hi        <= bus.address[0];
          end
        end
        CMD: begin
          if (bus.mem_cmd_ready) begin
            bus.mem_cmd_en <= 1'b0;
            cnt            <= '0;
            state          <= bus.mem_cmd ? WR_RECOVER : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.mem_rdata_valid) begin
            bus.rdata    <= lane_hi ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
            bus.rdata_en <= 1'b1;
            state        <= IDLE;
          end else if (cnt == TO_LAST) begin
            bus.rdata       <= '1;
            bus.rdata_en    <= 1'b1;
            bus.err_timeout <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_RECOVER: begin
          if (cnt == WR_LAST)
            state <= IDLE;
          else
            cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_psram_bridge.sv
// Scoreboard bench for ip_psram_bridge: expected read bytes are queued when a
// read is issued and compared whenever the bridge strobes rdata_en.
module tb_ip_psram_bridge;
  localparam int unsigned T = 16;
  localparam int unsigned W = 4;

  logic clk;
  logic reset;
  ip_psram_bridge_if bus ();

  ip_psram_bridge #(
    .TIMEOUT_CYCLES(T),
    .WRITE_RECOVERY(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Read-data monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rdata_en === 1'b1) begin
        if (exp_q.size() == 0) check("rdata_unexpected", 1, 0);
        else check("rdata", bus.rdata, exp_q.pop_front());
      end else if (bus.rdata !== 8'h00) begin
        check("rdata_idle_zero", bus.rdata, 0);
      end
    end
  end

  task automatic check_reset_vals(input string pfx, input logic calib);
    check({pfx, "_busy"}, bus.busy, !calib);
    check({pfx, "_cmd_en"}, bus.mem_cmd_en, 0);
    check({pfx, "_cmd"}, bus.mem_cmd, 0);
    check({pfx, "_addr"}, bus.mem_addr, 0);
    check({pfx, "_wdata"}, bus.mem_wdata, 0);
    check({pfx, "_wmask"}, bus.mem_wmask, 2'b11);
    check({pfx, "_rdata"}, bus.rdata, 0);
    check({pfx, "_rdata_en"}, bus.rdata_en, 0);
    check({pfx, "_err"}, bus.err_timeout, 0);
  endtask

  // Called just after a negedge. d = cycles with ready low, lat = core latency
  // after acceptance, give = 0 lets the read time out.
  task automatic do_read(input logic [21:0] a, input logic [15:0] word,
                         input int d, input int lat, input bit give);
    int n;
    int exp_n;
    bit stable;
    logic [7:0] eb;
    eb    = give ? (a[0] ? word[15:8] : word[7:0]) : 8'hFF;
    exp_n = give ? d + 3 + lat : d + int'(T) + 2;
    exp_q.push_back(eb);
    bus.rd = 1'b1;
    bus.wr = 1'b0;
    bus.address = a;
    bus.mem_cmd_ready = (d == 0);
    bus.mem_rdata_valid = 1'b0;
    n = 0;
    stable = 1'b1;
    do begin
      @(negedge clk);
      n++;
      bus.mem_rdata_valid = give && (n == d + 2 + lat);
      bus.mem_rdata = bus.mem_rdata_valid ? word : 16'hDEAD;
      if (n == 1) begin
        bus.rd = 1'b0;
        check("rd_cmd_en", bus.mem_cmd_en, 1);
        check("rd_cmd", bus.mem_cmd, 0);
        check("rd_addr", bus.mem_addr, a[21:1]);
        check("rd_busy_high", bus.busy, 1);
      end else if (n <= d + 1) begin
        if (!(bus.mem_cmd_en === 1'b1 && bus.mem_cmd === 1'b0 &&
              bus.mem_addr === a[21:1] && bus.rdata_en === 1'b0))
          stable = 1'b0;
      end
      if (d > 0 && n == d + 1) bus.mem_cmd_ready = 1'b1;
    end while (bus.rdata_en !== 1'b1 && n < 400);
    if (d > 0) check("rd_hold_stable", stable, 1);
    check("rd_latency", n, exp_n);
    check("rd_busy_low", bus.busy, 0);
    bus.mem_rdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] d8);
    int n;
    int en_cycles;
    bus.wr = 1'b1;
    bus.rd = 1'b0;
    bus.address = a;
    bus.wdata = d8;
    bus.mem_cmd_ready = 1'b1;
    n = 0;
    en_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.wr = 1'b0;
        check("wr_cmd", bus.mem_cmd, 1);
        check("wr_addr", bus.mem_addr, a[21:1]);
        check("wr_wdata", bus.mem_wdata, {d8, d8});
        check("wr_wmask", bus.mem_wmask, a[0] ? 2'b01 : 2'b10);
      end
      if (bus.mem_cmd_en === 1'b1) en_cycles++;
    end while (bus.busy !== 1'b0 && n < 100);
    check("wr_busy_low_cycle", n, W + 2);
    check("wr_cmd_en_cycles", en_cycles, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int saw_en;
    reset = 1'b1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.address = '0;
    bus.wdata = '0;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_calib_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst", 1'b0);
    bus.mem_calib_done = 1'b1;
    #1 check("rst_busy_calib", bus.busy, 0);
    bus.mem_calib_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Requests are ignored until calibration completes.
    bus.rd = 1'b1;
    bus.address = 22'h2468AD;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.mem_cmd_en !== 1'b0) bad++;
    end
    check("nocalib_hold", bad, 0);
    bus.mem_calib_done = 1'b1;
    do_read(22'h2468AD, 16'hBEEF, 0, 2, 1'b1);

    do_write(22'h000003, 8'hA5);
    do_read(22'h000010, 16'h3C5A, 0, 7, 1'b1);
    do_read(22'h000011, 16'h3C5A, 0, 7, 1'b1);
    do_read(22'h000020, 16'h1234, 0, 0, 1'b1);
    do_write(22'h000004, 8'h5C);
    do_read(22'h000021, 16'h1234, 0, 1, 1'b1);
    do_read(22'h3FFFFF, 16'h9876, 20, 3, 1'b1);
    check("no_timeout_yet", bus.err_timeout, 0);

    // Timeout, then a late valid that must be ignored.
    do_read(22'h000040, 16'h0000, 0, 0, 1'b0);
    check("err_timeout_set", bus.err_timeout, 1);
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata = 16'h1111;
    saw_en = 0;
    @(negedge clk);
    bus.mem_rdata_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rdata_en !== 1'b0) saw_en++;
    end
    check("late_valid_ignored", saw_en, 0);
    do_read(22'h000041, 16'hAA55, 0, 1, 1'b1);
    check("err_timeout_sticky", bus.err_timeout, 1);

    // Asynchronous reset while a command is pending.
    bus.rd = 1'b1;
    bus.address = 22'h000055;
    bus.mem_cmd_ready = 1'b0;
    @(negedge clk);
    bus.rd = 1'b0;
    check("mc_cmd_en_pre", bus.mem_cmd_en, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("mc", 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(22'h000101, 16'h7E81, 0, 2, 1'b1);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
